// File: rtl/vga_plot_scheduler_if.sv
// Pixel-scheduler bus: two box requesters, a clear requester and the
// single pixel-write port toward the VGA adapter.
interface vga_plot_scheduler_if;
  logic       iReq0;
  logic       iReq1;
  logic [7:0] iX0;
  logic [7:0] iX1;
  logic [6:0] iY0;
  logic [6:0] iY1;
  logic [2:0] iColour0;
  logic [2:0] iColour1;
  logic       iClear;
  logic       oAck0;
  logic       oAck1;
  logic       oAckClear;
  logic       oBusy;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oPlot;
  logic       oDone;

  // Requester side: drives requests, observes grants and the pixel stream
  modport master (
    output iReq0, iReq1, iX0, iX1, iY0, iY1, iColour0, iColour1, iClear,
    input  oAck0, oAck1, oAckClear, oBusy, oX, oY, oColour, oPlot, oDone
  );

  // Scheduler side
  modport slave (
    input  iReq0, iReq1, iX0, iX1, iY0, iY1, iColour0, iColour1, iClear,
    output oAck0, oAck1, oAckClear, oBusy, oX, oY, oColour, oPlot, oDone
  );
endinterface

// File: rtl/vga_plot_scheduler.sv
// Arbiter and pixel sequencer for the VGA adapter's single write port.
// Serves a full-screen clear ahead of 4x4 box draws, alternates between
// the two box requesters when both wait, and emits one pixel per clock.
module vga_plot_scheduler #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120,
  parameter int BOX_LOG2        = 2
) (
  input logic           iClock,
  input logic           iReset,
  vga_plot_scheduler_if.slave bus
);

  localparam int CW = 2 * BOX_LOG2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BOX   = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [8:0] X_LIM  = 9'(X_SCREEN_PIXELS);
  localparam logic [7:0] Y_LIM  = 8'(Y_SCREEN_PIXELS);
  localparam logic [7:0] X_LAST = 8'(X_SCREEN_PIXELS - 1);
  localparam logic [6:0] Y_LAST = 7'(Y_SCREEN_PIXELS - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last;
  logic          r_rrPtr;
  logic [7:0]    r_bx;
  logic [6:0]    r_by;
  logic [7:0]    r_cx;
  logic [6:0]    r_cy;

  logic          r_ack0;
  logic          r_ack1;
  logic          r_ackClear;
  logic          r_busy;
  logic [7:0]    r_x;
  logic [6:0]    r_y;
  logic [2:0]    r_colour;
  logic          r_plot;
  logic          r_done;

  logic          w_grant0;
  logic          w_grant1;
  logic [7:0]    w_selX;
  logic [6:0]    w_selY;
  logic [2:0]    w_selColour;
  logic          w_selOnScreen;
  logic [8:0]    w_boxX;
  logic [7:0]    w_boxY;
  logic          w_boxOnScreen;

  // Box arbitration: a lone requester wins outright; when both wait, the
  // round-robin pointer names the one that was not served last.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (bus.iReq0 && bus.iReq1) begin
      w_grant0 = ~r_rrPtr;
      w_grant1 = r_rrPtr;
    end else begin
      w_grant0 = bus.iReq0;
      w_grant1 = bus.iReq1;
    end
  end

  // Select the winning port's job parameters and test its first pixel
  always_comb begin
    w_selX        = w_grant1 ? bus.iX1 : bus.iX0;
    w_selY        = w_grant1 ? bus.iY1 : bus.iY0;
    w_selColour   = w_grant1 ? bus.iColour1 : bus.iColour0;
    w_selOnScreen = ({1'b0, w_selX} < X_LIM) && ({1'b0, w_selY} < Y_LIM);
  end

  // Current box pixel, summed one bit wider so off-screen pixels are caught
  always_comb begin
    w_boxX        = {1'b0, r_bx} + 9'(r_cnt[BOX_LOG2-1:0]);
    w_boxY        = {1'b0, r_by} + 8'(r_cnt[CW-1:BOX_LOG2]);
    w_boxOnScreen = (w_boxX < X_LIM) && (w_boxY < Y_LIM);
  end

  // Job sequencer: grants in IDLE, streams pixels in BOX/CLEAR, then a
  // single DONE cycle. Every output is a register; grant and done strobes
  // default low so they pulse for exactly one cycle.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_last     <= 1'b0;
      r_rrPtr    <= 1'b0;
      r_bx       <= '0;
      r_by       <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_ackClear <= 1'b0;
      r_busy     <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_colour   <= '0;
      r_plot     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_ackClear <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_plot <= 1'b0;
          if (bus.iClear) begin
            r_state    <= S_CLEAR;
            r_ackClear <= 1'b1;
            r_busy     <= 1'b1;
            r_x        <= '0;
            r_y        <= '0;
            r_colour   <= '0;
            r_plot     <= 1'b1;
            r_cx       <= 8'd1;
            r_cy       <= '0;
            r_last     <= 1'b0;
          end else if (w_grant0 || w_grant1) begin
            r_state  <= S_BOX;
            r_ack0   <= w_grant0;
            r_ack1   <= w_grant1;
            r_busy   <= 1'b1;
            r_bx     <= w_selX;
            r_by     <= w_selY;
            r_x      <= w_selX;
            r_y      <= w_selY;
            r_colour <= w_selColour;
            r_plot   <= w_selOnScreen;
            r_cnt    <= CW'(1);
            r_last   <= 1'b0;
            r_rrPtr  <= w_grant0;
          end
        end
        S_BOX: begin
          if (r_last) begin
            r_plot  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_x    <= w_boxX[7:0];
            r_y    <= w_boxY[6:0];
            r_plot <= w_boxOnScreen;
            if (r_cnt == '1) begin
              r_last <= 1'b1;
            end
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CLEAR: begin
          if (r_last) begin
            r_plot  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_x    <= r_cx;
            r_y    <= r_cy;
            r_plot <= 1'b1;
            if (r_cx == X_LAST) begin
              r_cx <= '0;
              if (r_cy == Y_LAST) begin
                r_last <= 1'b1;
              end else begin
                r_cy <= r_cy + 7'd1;
              end
            end else begin
              r_cx <= r_cx + 8'd1;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_plot  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.oAck0     = r_ack0;
  assign bus.oAck1     = r_ack1;
  assign bus.oAckClear = r_ackClear;
  assign bus.oBusy     = r_busy;
  assign bus.oX        = r_x;
  assign bus.oY        = r_y;
  assign bus.oColour   = r_colour;
  assign bus.oPlot     = r_plot;
  assign bus.oDone     = r_done;

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Self-checking bench for vga_plot_scheduler: each scenario fills an
// expected per-cycle trace from the job rules and compares it with the
// observed trace, cycle by cycle.
module tb_vga_plot_scheduler;

  localparam int MAXC = 19300;

  logic iClock = 1'b0;
  logic iReset;

  vga_plot_scheduler_if bus ();

  vga_plot_scheduler dut (
    .iClock (iClock),
    .iReset (iReset),
    .bus    (bus)
  );

  always #5 iClock = ~iClock;

  int testsRun = 0;
  int failed   = 0;

  logic [23:0] expWord [MAXC];
  logic [23:0] obsWord [MAXC];
  logic        autoDrop0;
  logic        autoDrop1;
  int          modelPtr;

  // Pack one cycle's outputs; pixel fields only matter while plotting
  function automatic logic [23:0] pack(input logic a0, input logic a1,
      input logic ac, input logic busy, input logic done, input logic plot,
      input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    return {a0, a1, ac, busy, done, plot, plot ? {x, y, c} : 18'd0};
  endfunction

  task automatic clearExp(input int n);
    for (int i = 0; i < n; i++) expWord[i] = '0;
  endtask

  // Reference: a box granted so that its ack shows at trace index s
  task automatic modelBox(input int s, input logic [7:0] bx,
      input logic [6:0] by, input logic [2:0] col, input int which);
    int x;
    int y;
    for (int i = 0; i < 16; i++) begin
      x = int'(bx) + (i % 4);
      y = int'(by) + (i / 4);
      expWord[s + i] = pack(which == 0 && i == 0, which == 1 && i == 0, 1'b0,
                            1'b1, 1'b0, (x < 160) && (y < 120),
                            8'(x), 7'(y), col);
    end
    expWord[s + 16] = pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 7'd0, 3'd0);
    expWord[s + 17] = '0;
    modelPtr = (which == 0) ? 1 : 0;
  endtask

  // Reference: a clear whose ack shows at trace index s
  task automatic modelClear(input int s);
    for (int i = 0; i < 19200; i++) begin
      expWord[s + i] = pack(1'b0, 1'b0, i == 0, 1'b1, 1'b0, 1'b1,
                            8'(i % 160), 7'(i / 160), 3'd0);
    end
    expWord[s + 19200] = pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 7'd0, 3'd0);
    expWord[s + 19201] = '0;
  endtask

  // Record n cycles of outputs; requesters withdraw on their own ack
  task automatic observe(input int n, input int clearAt);
    for (int i = 0; i < n; i++) begin
      @(negedge iClock);
      obsWord[i] = pack(bus.oAck0, bus.oAck1, bus.oAckClear, bus.oBusy,
                        bus.oDone, bus.oPlot, bus.oX, bus.oY, bus.oColour);
      if (bus.oAck0 && autoDrop0) bus.iReq0 = 1'b0;
      if (bus.oAck1 && autoDrop1) bus.iReq1 = 1'b0;
      if (bus.oAckClear) bus.iClear = 1'b0;
      if (i == clearAt) bus.iClear = 1'b1;
    end
  endtask

  task automatic raiseBox(input int which, input logic [7:0] bx,
      input logic [6:0] by, input logic [2:0] col);
    if (which == 0) begin
      bus.iX0 = bx; bus.iY0 = by; bus.iColour0 = col; bus.iReq0 = 1'b1;
    end else begin
      bus.iX1 = bx; bus.iY1 = by; bus.iColour1 = col; bus.iReq1 = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [23:0] raw;
    iReset = 1'b1;
    bus.iReq0 = 0; bus.iReq1 = 0; bus.iClear = 0;
    bus.iX0 = 0; bus.iX1 = 0; bus.iY0 = 0; bus.iY1 = 0;
    bus.iColour0 = 0; bus.iColour1 = 0;
    autoDrop0 = 1'b1; autoDrop1 = 1'b1;
    repeat (3) @(negedge iClock);
    raw = {bus.oAck0, bus.oAck1, bus.oAckClear, bus.oBusy, bus.oDone,
           bus.oPlot, bus.oX, bus.oY, bus.oColour};
    testsRun++;
    if (raw !== 24'd0) begin
      failed++;
      $display("[TB] FAIL reset_outputs got %h expected %h", raw, 24'd0);
    end
    iReset = 1'b0;
    modelPtr = 0;
    @(negedge iClock);
    raw = {bus.oAck0, bus.oAck1, bus.oAckClear, bus.oBusy, bus.oDone, bus.oPlot};
    testsRun++;
    if (raw !== 24'd0) begin
      failed++;
      $display("[TB] FAIL idle_after_reset got %h expected %h", raw, 24'd0);
    end
  endtask

  task automatic test_contention();
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] c0, c1;
    int which;
    x0 = 8'($urandom_range(0, 255)); y0 = 7'($urandom_range(0, 127));
    x1 = 8'($urandom_range(0, 255)); y1 = 7'($urandom_range(0, 127));
    c0 = 3'($urandom); c1 = 3'($urandom);
    autoDrop0 = 1'b0; autoDrop1 = 1'b0;
    clearExp(72);
    for (int j = 0; j < 4; j++) begin
      which = modelPtr;
      if (which == 0) modelBox(18 * j, x0, y0, c0, 0);
      else            modelBox(18 * j, x1, y1, c1, 1);
    end
    raiseBox(0, x0, y0, c0);
    raiseBox(1, x1, y1, c1);
    observe(72, -1);
    bus.iReq0 = 1'b0; bus.iReq1 = 1'b0;
    autoDrop0 = 1'b1; autoDrop1 = 1'b1;
    for (int i = 0; i < 72; i++) begin
      testsRun++;
      if (obsWord[i] !== expWord[i]) begin
        failed++;
        $display("[TB] FAIL contention cycle %0d got %h expected %h", i, obsWord[i], expWord[i]);
      end
    end
  endtask

  task automatic test_single_box();
    logic [7:0] bx;
    logic [6:0] by;
    logic [2:0] col;
    int which;
    for (int t = 0; t < 7; t++) begin
      if (t == 0) begin
        bx = 8'd10; by = 7'd20; col = 3'b101; which = 0;
      end else begin
        bx = 8'($urandom_range(0, 255)); by = 7'($urandom_range(0, 127));
        col = 3'($urandom); which = int'($urandom_range(0, 1));
      end
      clearExp(18);
      modelBox(0, bx, by, col, which);
      raiseBox(which, bx, by, col);
      observe(18, -1);
      for (int i = 0; i < 18; i++) begin
        testsRun++;
        if (obsWord[i] !== expWord[i]) begin
          failed++;
          $display("[TB] FAIL single_box %0d cycle %0d got %h expected %h", t, i, obsWord[i], expWord[i]);
        end
      end
    end
  endtask

  task automatic test_clipping();
    logic [7:0] bx;
    logic [6:0] by;
    int plots;
    for (int t = 0; t < 5; t++) begin
      if (t == 0) begin
        bx = 8'd158; by = 7'd118;
      end else begin
        bx = 8'($urandom_range(150, 255)); by = 7'($urandom_range(110, 127));
      end
      clearExp(18);
      modelBox(0, bx, by, 3'b011, 1);
      raiseBox(1, bx, by, 3'b011);
      observe(18, -1);
      plots = 0;
      for (int i = 0; i < 18; i++) begin
        plots += int'(obsWord[i][18]);
        testsRun++;
        if (obsWord[i] !== expWord[i]) begin
          failed++;
          $display("[TB] FAIL clipping %0d cycle %0d got %h expected %h", t, i, obsWord[i], expWord[i]);
        end
      end
      if (t == 0) begin
        testsRun++;
        if (plots !== 4) begin
          failed++;
          $display("[TB] FAIL clip_plot_count got %0d expected %0d", plots, 4);
        end
      end
    end
  endtask

  task automatic test_clear_priority();
    logic [7:0] bx;
    logic [6:0] by;
    logic [2:0] col;
    bx = 8'($urandom_range(0, 155)); by = 7'($urandom_range(0, 115));
    col = 3'($urandom);
    clearExp(19220);
    modelClear(0);
    modelBox(19202, bx, by, col, 1);
    raiseBox(1, bx, by, col);
    bus.iClear = 1'b1;
    observe(19220, -1);
    for (int i = 0; i < 19220; i++) begin
      testsRun++;
      if (obsWord[i] !== expWord[i]) begin
        failed++;
        $display("[TB] FAIL clear_priority cycle %0d got %h expected %h", i, obsWord[i], expWord[i]);
      end
    end
  endtask

  task automatic test_no_preemption();
    logic [7:0] bx;
    logic [6:0] by;
    logic [2:0] col;
    bx = 8'($urandom_range(0, 155)); by = 7'($urandom_range(0, 115));
    col = 3'($urandom);
    clearExp(19220);
    modelBox(0, bx, by, col, 0);
    modelClear(18);
    raiseBox(0, bx, by, col);
    observe(19220, 5);
    for (int i = 0; i < 19220; i++) begin
      testsRun++;
      if (obsWord[i] !== expWord[i]) begin
        failed++;
        $display("[TB] FAIL no_preemption cycle %0d got %h expected %h", i, obsWord[i], expWord[i]);
      end
    end
  endtask

  task automatic test_reset_mid_box();
    logic [7:0] bx;
    logic [6:0] by;
    logic [2:0] col;
    logic [23:0] raw;
    bx = 8'($urandom_range(0, 155)); by = 7'($urandom_range(0, 115));
    col = 3'($urandom);
    clearExp(18);
    modelBox(0, bx, by, col, 0);
    autoDrop0 = 1'b0;
    raiseBox(0, bx, by, col);
    observe(8, -1);
    for (int i = 0; i < 8; i++) begin
      testsRun++;
      if (obsWord[i] !== expWord[i]) begin
        failed++;
        $display("[TB] FAIL pre_reset cycle %0d got %h expected %h", i, obsWord[i], expWord[i]);
      end
    end
    iReset = 1'b1;
    #1;
    raw = {bus.oAck0, bus.oAck1, bus.oAckClear, bus.oBusy, bus.oDone,
           bus.oPlot, bus.oX, bus.oY, bus.oColour};
    testsRun++;
    if (raw !== 24'd0) begin
      failed++;
      $display("[TB] FAIL async_reset_drop got %h expected %h", raw, 24'd0);
    end
    @(negedge iClock);
    raw = {bus.oAck0, bus.oAck1, bus.oAckClear, bus.oBusy, bus.oDone,
           bus.oPlot, bus.oX, bus.oY, bus.oColour};
    testsRun++;
    if (raw !== 24'd0) begin
      failed++;
      $display("[TB] FAIL reset_held got %h expected %h", raw, 24'd0);
    end
    iReset = 1'b0;
    modelPtr = 0;
    autoDrop0 = 1'b1;
    clearExp(18);
    modelBox(0, bx, by, col, 0);
    observe(18, -1);
    for (int i = 0; i < 18; i++) begin
      testsRun++;
      if (obsWord[i] !== expWord[i]) begin
        failed++;
        $display("[TB] FAIL regrant cycle %0d got %h expected %h", i, obsWord[i], expWord[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_box();
    test_clipping();
    test_clear_priority();
    test_no_preemption();
    test_reset_mid_box();
    $display("[TB] %0d tests run, %0d failed", testsRun, failed);
    $finish;
  end

endmodule

// File: doc/vga_plot_scheduler.md
# vga_plot_scheduler

Sequencer and arbiter for the single pixel-write port of the VGA adapter. It accepts 4x4 box-draw requests from two independent requesters and a full-screen clear request, and serves them one at a time. Requests are granted by fixed clear priority, then round-robin between the two box requesters. Each granted job is expanded into a stream of one pixel per clock on oX/oY/oColour/oPlot, clipped to the screen.

## Interface
- X_SCREEN_PIXELS, 160, screen width; x range 0..159
- Y_SCREEN_PIXELS, 120, screen height; y range 0..119
- BOX_LOG2, 2, log2 of box edge; box is 4x4 = 16 pixels
- iClock  in  1  system clock; all state changes on the rising edge
- iReset  in  1  asynchronous, active-high reset
- iReq0 / iReq1  in  1  box request level from requester 0/1; held high until the matching ack
- iX0 / iX1  in  8  box top-left x; stable while request is high
- iY0 / iY1  in  7  box top-left y
- iColour0 / iColour1  in  3  box colour
- iClear  in  1  clear-screen request level; held until oAckClear
- oAck0 / oAck1 / oAckClear  out  1  one-cycle grant pulse; coordinates and colour are latched when it fires
- oBusy  out  1  high whenever state is not IDLE
- oX  out  8  pixel x
- oY  out  7  pixel y
- oColour  out  3  pixel colour
- oPlot  out  1  pixel write strobe to the VGA adapter
- oDone  out  1  one-cycle pulse when a job finishes

## Operation
- All outputs are registered. On reset, every output is 0, state is IDLE, and the round-robin pointer favours requester 0.
- States: IDLE, BOX, CLEAR, DONE.
- IDLE arbitration, evaluated each cycle:
  - If iClear is high: go to CLEAR and pulse oAckClear.
  - Else if exactly one of iReq0/iReq1 is high: grant that requester.
  - Else if both are high: grant the requester not served last. The pointer flips after each box grant.
- On a box grant: latch bx, by, and colour from the granted port, clear the pixel counter c[3:0], pulse oAckN, and go to BOX.
- BOX, one pixel per cycle for 16 cycles, row-major with x fastest:
  - oX = bx + c[1:0], oY = by + c[3:2].
  - Sums are computed 9/8 bits wide. If x > 159 or y > 119, oPlot = 0 for that cycle but the counter still advances (clipping).
  - After c = 15, go to DONE.
- CLEAR: scan y 0..119 (outer) and x 0..159 (inner), oColour = 0, oPlot = 1 on every cycle. After (159,119), go to DONE.
- DONE: oPlot = 0, oDone = 1 for one cycle, then IDLE.
- Jobs are never preempted. An iClear that arrives during BOX is served at the next IDLE, ahead of any pending box.
- A request still high after its own ack is treated as a new request at the next IDLE.
- Reset mid-job (BOX or CLEAR): state is abandoned, oPlot and all outputs drop to 0 asynchronously, and no oDone is issued.

## Timing
- Request sampled high in IDLE at edge k: during cycle k+1, oAck is high, oBusy is high, and the first pixel is valid with oPlot = 1 (unclipped).
- Box: 16 pixel cycles (k+1..k+16), oDone in cycle k+17, IDLE in cycle k+18. Earliest next grant edge is k+18, so 18 cycles per box.
- Clear: 19200 pixel cycles, then 1 DONE cycle, then IDLE.
- oAck*, oDone, oAckClear are each high for exactly one cycle per job.
- oX/oY/oColour hold their last values while oPlot = 0; they are not required to be 0 outside a job.

## Test plan
- Single box: iReq0 with (10,20), colour 3'b101, after reset.
  - oAck0 high for 1 cycle.
  - 16 consecutive oPlot cycles covering x 10..13 fastest, then y 20..23, colour 101.
  - oDone on the 17th cycle after grant; oBusy low afterwards.
- Contention: iReq0 and iReq1 both held high continuously.
  - Grants alternate 0,1,0,1, 18 cycles apart.
  - oAck never goes high for both in the same cycle.
- Clipping: box at (158,118).
  - Exactly 4 oPlot pulses: (158,118), (159,118), (158,119), (159,119).
  - Still 16 BOX cycles; oDone timing unchanged.
- Clear priority: iClear and iReq1 raised in the same IDLE cycle.
  - oAckClear first.
  - 19200 oPlot cycles with colour 0; first pixel (0,0), last pixel (159,119).
  - oDone, then oAck1 and the box.
- No preemption: iClear raised during pixel 5 of a box. The box completes all 16 pixels and oDone, then the clear is granted.
- Reset mid-box: iReset asserted during pixel 7.
  - oPlot drops in the same cycle; no oDone.
  - After release with iReq0 still high: re-grant, box redrawn from pixel 0.
